// File: rtl/perf_pkg.sv
// ---------------------------------------------------------------------------
// perf_pkg
// Shared types and constants for the performance-event counter stage.
//
// Contents:
//   PERF_WIDTH     default counter width (matches the scalar register file)
//   PERF_SAT       saturation value for a PERF_WIDTH counter
//   perf_state_t   counter FSM states (IDLE / RUN / FROZEN)
//   instr_class_t  class encoding of a retiring instruction
//   div_state_t    states of the CPI restoring divider
// ---------------------------------------------------------------------------
package perf_pkg;

    localparam int PERF_WIDTH = 19;
    localparam logic [PERF_WIDTH-1:0] PERF_SAT = {PERF_WIDTH{1'b1}};

    typedef enum logic [1:0] {
        PS_IDLE   = 2'd0,
        PS_RUN    = 2'd1,
        PS_FROZEN = 2'd2
    } perf_state_t;

    typedef enum logic [1:0] {
        IC_OTHER  = 2'd0,
        IC_ARITH  = 2'd1,
        IC_MEM    = 2'd2,
        IC_BRANCH = 2'd3
    } instr_class_t;

    typedef enum logic [1:0] {
        DV_IDLE = 2'd0,
        DV_BUSY = 2'd1,
        DV_DONE = 2'd2
    } div_state_t;

endpackage

// File: rtl/perf_divider.sv
// ---------------------------------------------------------------------------
// perf_divider
// Restoring unsigned divider producing one quotient bit per cycle.
//
// Handshake: start_i is sampled only while idle (busy_o low, done_o low).
// The operands are captured on the start edge; the following WIDTH cycles
// each retire one quotient bit, and done_o rises with the last bit. done_o
// and quotient_o then hold until abort_i or rst. A zero divisor skips the
// iteration and reports an all-ones quotient on the start edge itself.
// abort_i has priority over everything except rst.
//
// Ports:
//   clk         system clock, rising edge
//   rst         synchronous, active-high reset
//   abort_i     drop any division in progress and clear the result
//   start_i     begin a division with dividend_i / divisor_i
//   dividend_i  WIDTH-bit dividend
//   divisor_i   WIDTH-bit divisor
//   busy_o      division iterating
//   done_o      quotient_o holds a final value
//   quotient_o  result, forced to 0 until done_o
// ---------------------------------------------------------------------------
module perf_divider
    import perf_pkg::*;
#(
    parameter int WIDTH = PERF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             abort_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] quotient_o
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    div_state_t       state_q, state_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Partial remainder shifted left with the next dividend bit brought in.
    // quot_q doubles as the dividend shift register: its MSB is the next
    // dividend bit and quotient bits enter at the LSB.
    logic [WIDTH:0] shifted;
    logic           ge;

    assign shifted = {rem_q, quot_q[WIDTH-1]};
    assign ge      = (shifted >= {1'b0, dvs_q});

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        quot_d  = quot_q;
        dvs_d   = dvs_q;
        cnt_d   = cnt_q;

        if (abort_i) begin
            state_d = DV_IDLE;
            rem_d   = '0;
            quot_d  = '0;
            dvs_d   = '0;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                DV_IDLE: begin
                    if (start_i) begin
                        if (divisor_i == '0) begin
                            quot_d  = {WIDTH{1'b1}};
                            state_d = DV_DONE;
                        end else begin
                            quot_d  = dividend_i;
                            rem_d   = '0;
                            dvs_d   = divisor_i;
                            cnt_d   = '0;
                            state_d = DV_BUSY;
                        end
                    end
                end
                DV_BUSY: begin
                    // When ge, the difference is below the divisor and fits WIDTH bits.
                    rem_d  = ge ? WIDTH'(shifted - {1'b0, dvs_q}) : shifted[WIDTH-1:0];
                    quot_d = {quot_q[WIDTH-2:0], ge};
                    cnt_d  = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_STEP) begin
                        state_d = DV_DONE;
                    end
                end
                DV_DONE: begin
                    // Result holds until abort or reset.
                end
                default: begin
                    state_d = DV_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= DV_IDLE;
            rem_q   <= '0;
            quot_q  <= '0;
            dvs_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            quot_q  <= quot_d;
            dvs_q   <= dvs_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy_o     = (state_q == DV_BUSY);
    assign done_o     = (state_q == DV_DONE);
    assign quotient_o = (state_q == DV_DONE) ? quot_q : '0;

endmodule

// File: rtl/perf_counter_unit.sv
// ---------------------------------------------------------------------------
// perf_counter_unit
// Performance-event counter stage feeding the scalar register file
// (R28..R31 expose stall, arithmetic, memory and instruction counts).
//
// FSM: IDLE --start--> RUN --finish--> FROZEN; clear returns to IDLE from
// any state and zeroes every count. All counters saturate at all-ones.
// Every output is registered: an event sampled at edge N is visible after N.
//
// Optional feature, macro PERF_CPI_EN: on entry to FROZEN a restoring
// divider computes cycle_count / instruction_count into cpi; cpi_valid
// rises WIDTH+1 cycles after FROZEN entry (1 cycle for a zero divisor).
// Without the macro cpi and cpi_valid are tied to 0.
//
// Ports:
//   clk, rst            clock (rising edge), synchronous active-high reset
//   start               one-cycle program-start pulse from fetch
//   clear               synchronous counter clear, returns to IDLE
//   wb_valid, wb_class  writeback retirement and its class
//   stall               pipeline held by the hazard unit this cycle
//   finish              end-of-program flag from the register file
//   stall_count, aritmetric_count, memory_count, instruction_count,
//   cycle_count         event counters (WIDTH bits)
//   running, frozen     state == RUN / state == FROZEN
//   cpi, cpi_valid      cycles per instruction and its valid flag
// ---------------------------------------------------------------------------
module perf_counter_unit
    import perf_pkg::*;
#(
    parameter int WIDTH = PERF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             clear,
    input  logic             wb_valid,
    input  logic [1:0]       wb_class,
    input  logic             stall,
    input  logic             finish,
    output logic [WIDTH-1:0] stall_count,
    output logic [WIDTH-1:0] aritmetric_count,
    output logic [WIDTH-1:0] memory_count,
    output logic [WIDTH-1:0] instruction_count,
    output logic [WIDTH-1:0] cycle_count,
    output logic             running,
    output logic             frozen,
    output logic [WIDTH-1:0] cpi,
    output logic             cpi_valid
);

    localparam logic [WIDTH-1:0] SAT = {WIDTH{1'b1}};

    perf_state_t      state_q, state_d;
    logic [WIDTH-1:0] stall_q, stall_d;
    logic [WIDTH-1:0] arith_q, arith_d;
    logic [WIDTH-1:0] mem_q,   mem_d;
    logic [WIDTH-1:0] instr_q, instr_d;
    logic [WIDTH-1:0] cycle_q, cycle_d;

    function automatic logic [WIDTH-1:0] sat_inc(input logic [WIDTH-1:0] v);
        return (v == SAT) ? v : v + WIDTH'(1);
    endfunction

    always_comb begin
        state_d = state_q;
        stall_d = stall_q;
        arith_d = arith_q;
        mem_d   = mem_q;
        instr_d = instr_q;
        cycle_d = cycle_q;

        if (clear) begin
            state_d = PS_IDLE;
            stall_d = '0;
            arith_d = '0;
            mem_d   = '0;
            instr_d = '0;
            cycle_d = '0;
        end else begin
            unique case (state_q)
                PS_IDLE: begin
                    // Events in the start cycle itself are not counted.
                    if (start) begin
                        state_d = PS_RUN;
                    end
                end
                PS_RUN: begin
                    cycle_d = sat_inc(cycle_q);
                    if (stall) begin
                        stall_d = sat_inc(stall_q);
                    end
                    if (wb_valid) begin
                        instr_d = sat_inc(instr_q);
                        case (instr_class_t'(wb_class))
                            IC_ARITH: arith_d = sat_inc(arith_q);
                            IC_MEM:   mem_d   = sat_inc(mem_q);
                            default:  ;
                        endcase
                    end
                    // The finish cycle is still counted above.
                    if (finish) begin
                        state_d = PS_FROZEN;
                    end
                end
                PS_FROZEN: begin
                    // Counts hold; only clear or rst leave this state.
                end
                default: begin
                    state_d = PS_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= PS_IDLE;
            stall_q <= '0;
            arith_q <= '0;
            mem_q   <= '0;
            instr_q <= '0;
            cycle_q <= '0;
        end else begin
            state_q <= state_d;
            stall_q <= stall_d;
            arith_q <= arith_d;
            mem_q   <= mem_d;
            instr_q <= instr_d;
            cycle_q <= cycle_d;
        end
    end

    assign stall_count       = stall_q;
    assign aritmetric_count  = arith_q;
    assign memory_count      = mem_q;
    assign instruction_count = instr_q;
    assign cycle_count       = cycle_q;
    assign running           = (state_q == PS_RUN);
    assign frozen            = (state_q == PS_FROZEN);

`ifdef PERF_CPI_EN
    // High during the first FROZEN cycle, when the counters already hold
    // their final values (the finish cycle was counted on the entry edge).
    logic frozen_entry_q;
    logic frozen_entry_d;
    logic div_busy;

    assign frozen_entry_d = (state_q == PS_RUN) && (state_d == PS_FROZEN);

    always_ff @(posedge clk) begin
        if (rst) begin
            frozen_entry_q <= 1'b0;
        end else begin
            frozen_entry_q <= frozen_entry_d;
        end
    end

    perf_divider #(
        .WIDTH(WIDTH)
    ) u_div (
        .clk        (clk),
        .rst        (rst),
        .abort_i    (clear),
        .start_i    (frozen_entry_q && !div_busy),
        .dividend_i (cycle_q),
        .divisor_i  (instr_q),
        .busy_o     (div_busy),
        .done_o     (cpi_valid),
        .quotient_o (cpi)
    );
`else
    assign cpi       = '0;
    assign cpi_valid = 1'b0;
`endif

endmodule

// File: tb/tb_perf_counter_unit.sv
// ---------------------------------------------------------------------------
// tb_perf_counter_unit
// Directed bench for perf_counter_unit. Two instances share the stimulus:
// the default 19-bit build and a 4-bit build used for saturation. A
// reference model predicts every output each cycle; predictions are queued
// when a step is driven and popped after the following rising edge.
// ---------------------------------------------------------------------------
module tb_perf_counter_unit;

    localparam int W  = 19;
    localparam int W4 = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0, clear = 1'b0, wb_valid = 1'b0, stall = 1'b0, finish = 1'b0;
    logic [1:0] wb_class = 2'd0;

    logic [W-1:0]  stall_count, aritmetric_count, memory_count, instruction_count, cycle_count, cpi;
    logic          running, frozen, cpi_valid;
    logic [W4-1:0] s4_stall, s4_arith, s4_mem, s4_instr, s4_cycle, s4_cpi;
    logic          s4_running, s4_frozen, s4_cpi_valid;

    int n_assert = 0;
    int n_fail   = 0;

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    perf_counter_unit #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .clear(clear), .wb_valid(wb_valid),
        .wb_class(wb_class), .stall(stall), .finish(finish),
        .stall_count(stall_count), .aritmetric_count(aritmetric_count),
        .memory_count(memory_count), .instruction_count(instruction_count),
        .cycle_count(cycle_count), .running(running), .frozen(frozen),
        .cpi(cpi), .cpi_valid(cpi_valid)
    );

    perf_counter_unit #(.WIDTH(W4)) dut4 (
        .clk(clk), .rst(rst), .start(start), .clear(clear), .wb_valid(wb_valid),
        .wb_class(wb_class), .stall(stall), .finish(finish),
        .stall_count(s4_stall), .aritmetric_count(s4_arith),
        .memory_count(s4_mem), .instruction_count(s4_instr),
        .cycle_count(s4_cycle), .running(s4_running), .frozen(s4_frozen),
        .cpi(s4_cpi), .cpi_valid(s4_cpi_valid)
    );

    // ---------------- reference model (index 0: 19-bit, 1: 4-bit) ----------------
    int m_st[2], m_cyc[2], m_stl[2], m_ari[2], m_mem[2], m_ins[2];
    int m_cpi[2], m_cv[2], m_dcnt[2], m_dval[2];
    int m_sat[2] = '{(1 << W) - 1, (1 << W4) - 1};
    int m_w[2]   = '{W, W4};

    function automatic int sinc(int v, int k);
        return (v >= m_sat[k]) ? v : v + 1;
    endfunction

    function automatic void model_step(int k);
        if (rst || clear) begin
            m_st[k] = 0; m_cyc[k] = 0; m_stl[k] = 0; m_ari[k] = 0; m_mem[k] = 0; m_ins[k] = 0;
            m_cpi[k] = 0; m_cv[k] = 0; m_dcnt[k] = 0; m_dval[k] = 0;
        end else begin
            if (m_st[k] == 2 && m_dcnt[k] > 0) begin
                m_dcnt[k]--;
                if (m_dcnt[k] == 0) begin
                    m_cv[k]  = 1;
                    m_cpi[k] = m_dval[k];
                end
            end
            if (m_st[k] == 0) begin
                if (start) m_st[k] = 1;
            end else if (m_st[k] == 1) begin
                m_cyc[k] = sinc(m_cyc[k], k);
                if (stall) m_stl[k] = sinc(m_stl[k], k);
                if (wb_valid) begin
                    m_ins[k] = sinc(m_ins[k], k);
                    if (wb_class == 2'd1) m_ari[k] = sinc(m_ari[k], k);
                    if (wb_class == 2'd2) m_mem[k] = sinc(m_mem[k], k);
                end
                if (finish) begin
                    m_st[k] = 2;
`ifdef PERF_CPI_EN
                    m_dcnt[k] = (m_ins[k] == 0) ? 1 : m_w[k] + 1;
                    m_dval[k] = (m_ins[k] == 0) ? m_sat[k] : m_cyc[k] / m_ins[k];
`endif
                end
            end
        end
    endfunction

    function automatic logic [5*W+W+2:0] exp_main();
        return {W'(m_stl[0]), W'(m_ari[0]), W'(m_mem[0]), W'(m_ins[0]), W'(m_cyc[0]),
                1'(m_st[0] == 1), 1'(m_st[0] == 2), W'(m_cpi[0]), 1'(m_cv[0])};
    endfunction

    function automatic logic [5*W4+W4+2:0] exp_small();
        return {W4'(m_stl[1]), W4'(m_ari[1]), W4'(m_mem[1]), W4'(m_ins[1]), W4'(m_cyc[1]),
                1'(m_st[1] == 1), 1'(m_st[1] == 2), W4'(m_cpi[1]), 1'(m_cv[1])};
    endfunction

    // ---------------- scoreboard ----------------
    logic [5*W+W+2:0]   exp_q[$];
    logic [5*W4+W4+2:0] exp4_q[$];

    task automatic compare_outputs();
        logic [5*W+W+2:0]   obs, e;
        logic [5*W4+W4+2:0] obs4, e4;
        obs  = {stall_count, aritmetric_count, memory_count, instruction_count, cycle_count,
                running, frozen, cpi, cpi_valid};
        obs4 = {s4_stall, s4_arith, s4_mem, s4_instr, s4_cycle, s4_running, s4_frozen,
                s4_cpi, s4_cpi_valid};
        e  = exp_q.pop_front();
        e4 = exp4_q.pop_front();
        n_assert++;
        assert (obs === e) else begin
            n_fail++;
            $error("FAIL snapshot_w19 obs=%h exp=%h", obs, e);
        end
        n_assert++;
        assert (obs4 === e4) else begin
            n_fail++;
            $error("FAIL snapshot_w4 obs=%h exp=%h", obs4, e4);
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
        end
    endtask

    // ---------------- driver ----------------
    task automatic step(input logic rs, input logic st, input logic cl, input logic wv,
                        input logic [1:0] wc, input logic sl, input logic fi);
        @(negedge clk);
        rst = rs; start = st; clear = cl; wb_valid = wv; wb_class = wc; stall = sl; finish = fi;
        model_step(0);
        model_step(1);
        exp_q.push_back(exp_main());
        exp4_q.push_back(exp_small());
        @(posedge clk);
        #1;
        compare_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 2'd0, 0, 0);
    endtask

    task automatic rand_events(input int n, input logic allow_start, input logic allow_finish);
        for (int i = 0; i < n; i++)
            step(0, allow_start & 1'($urandom_range(0, 1)), 0, 1'($urandom_range(0, 1)),
                 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                 allow_finish & 1'($urandom_range(0, 1)));
    endtask

    int cls[10] = '{1, 1, 2, 0, 3, 1, 2, 2, 1, 0};

    initial begin
        // Reset
        step(1, 0, 0, 0, 2'd0, 0, 0);
        step(1, 1, 0, 1, 2'd1, 1, 1);
        chk("reset_cycle", 32'(cycle_count), 0);
        chk("reset_running", 32'(running), 0);
        chk("reset_cpi_valid", 32'(cpi_valid), 0);

        // Idle gating: events without start
        rand_events(4, 1'b0, 1'b1);
        chk("idle_instr", 32'(instruction_count), 0);

        // Start cycle carries events that must not count
        step(0, 1, 0, 1, 2'd1, 1, 0);
        chk("start_running", 32'(running), 1);
        chk("start_instr", 32'(instruction_count), 0);

        // Basic count
        for (int i = 0; i < 10; i++) step(0, 0, 0, 1, 2'(cls[i]), 0, 0);
        chk("basic_instr", 32'(instruction_count), 10);
        chk("basic_arith", 32'(aritmetric_count), 4);
        chk("basic_mem", 32'(memory_count), 3);
        chk("basic_stall", 32'(stall_count), 0);
        chk("basic_cycle", 32'(cycle_count), 10);

        // Start while running is ignored
        step(0, 1, 0, 0, 2'd0, 0, 0);
        chk("restart_cycle", 32'(cycle_count), 11);

        // Clear in RUN
        step(0, 0, 1, 1, 2'd1, 1, 0);
        chk("clear_run_cycle", 32'(cycle_count), 0);
        chk("clear_run_running", 32'(running), 0);

        // Overlap and freeze
        step(0, 1, 0, 0, 2'd0, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 2'd1, 1, 0);
        step(0, 0, 0, 0, 2'd0, 0, 1);
        chk("overlap_stall", 32'(stall_count), 5);
        chk("overlap_arith", 32'(aritmetric_count), 5);
        chk("overlap_frozen", 32'(frozen), 1);
        rand_events(20, 1'b1, 1'b1);
        step(0, 1, 0, 0, 2'd0, 0, 0);
        chk("frozen_hold_stall", 32'(stall_count), 5);
        chk("frozen_hold_cycle", 32'(cycle_count), 6);
        chk("frozen_start_ignored", 32'(frozen), 1);

        // Clear and start together
        step(0, 0, 1, 0, 2'd0, 0, 0);
        step(0, 1, 1, 0, 2'd0, 0, 0);
        chk("clear_start_running", 32'(running), 0);
        idle(1);
        chk("clear_start_still_idle", 32'(running), 0);

        // Saturation on the 4-bit instance
        step(0, 1, 0, 0, 2'd0, 0, 0);
        rand_events(20, 1'b1, 1'b0);
        chk("sat_cycle_w4", 32'(s4_cycle), 15);
        chk("sat_cycle_w19", 32'(cycle_count), 20);
        idle(3);
        chk("sat_hold_w4", 32'(s4_cycle), 15);
        step(0, 0, 0, 0, 2'd0, 0, 1);

        // CPI: 100 cycles, 25 instructions
        step(0, 0, 1, 0, 2'd0, 0, 0);
        step(0, 1, 0, 0, 2'd0, 0, 0);
        for (int i = 0; i < 100; i++) step(0, 0, 0, 1'(i % 4 == 0), 2'd0, 0, 1'(i == 99));
        chk("cpi_cycle", 32'(cycle_count), 100);
        chk("cpi_instr", 32'(instruction_count), 25);
        idle(25);
`ifdef PERF_CPI_EN
        chk("cpi_value", 32'(cpi), 4);
        chk("cpi_valid", 32'(cpi_valid), 1);
`else
        chk("cpi_tied", 32'(cpi), 0);
        chk("cpi_valid_tied", 32'(cpi_valid), 0);
`endif

        // CPI: zero instructions
        step(0, 0, 1, 0, 2'd0, 0, 0);
        step(0, 1, 0, 0, 2'd0, 0, 0);
        for (int i = 0; i < 10; i++) step(0, 0, 0, 0, 2'd0, 1, 1'(i == 9));
        idle(3);
`ifdef PERF_CPI_EN
        chk("cpi_zero_div", 32'(cpi), 32'h7FFFF);
`else
        chk("cpi_zero_tied", 32'(cpi), 0);
`endif

        // Clear during a division aborts it
        step(0, 0, 1, 0, 2'd0, 0, 0);
        step(0, 1, 0, 0, 2'd0, 0, 0);
        for (int i = 0; i < 6; i++) step(0, 0, 0, 1, 2'd2, 0, 1'(i == 5));
        idle(5);
        step(0, 0, 1, 0, 2'd0, 0, 0);
        idle(25);
        chk("abort_cpi_valid", 32'(cpi_valid), 0);
        chk("abort_cpi", 32'(cpi), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
